// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: control FSM for an oversampled UART receiver.
// Turns a baud_tick enable and the raw serial line into shift/parity_load/
// check_stop strobes for an external datapath, then holds the completed-frame
// handshake (frame_valid/frame_err) and a sticky overrun flag.
//
// Build option: define RX_SEQ_PARITY_EN to include the PARITY bit-time and
// fold parity_error into frame_err. Without it DATA goes straight to STOP and
// parity_load is tied low.
//
// OVERSAMPLE must be 8 or 16; DATA_BITS >= 1.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, waiting for a low sample on baud_tick
// START  | half a bit-time into the start bit, rejects glitches at midpoint
// DATA   | one bit-time per data bit, shift strobe at each bit centre
// PARITY | one bit-time, parity_load strobe at the bit centre
// STOP   | one bit-time, check_stop strobe at the bit centre, back to IDLE

module rx_frame_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_tick,
  input  logic rx_inp,
  input  logic parity_error,
  input  logic stop_error,
  input  logic frame_ready,
  output logic shift,
  output logic parity_load,
  output logic check_stop,
  output logic busy,
  output logic frame_valid,
  output logic frame_err,
  output logic overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  // Set once the line has been seen high in IDLE; a line that is already low
  // when reset releases is not a start edge.
  logic          armed, armed_nxt;
  logic          err_now;

`ifdef RX_SEQ_PARITY_EN
  assign err_now = parity_error | stop_error;
`else
  // Parity flag has no consumer in this build.
  logic unused_parity;
  assign unused_parity = parity_error;
  assign err_now       = stop_error;
  assign parity_load   = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  // State, sample counter, bit index and line-arming flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      armed <= armed_nxt;
    end
  end

  // Next-state and strobe decode; nothing moves without baud_tick.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    armed_nxt  = armed;
    shift      = 1'b0;
    check_stop = 1'b0;
`ifdef RX_SEQ_PARITY_EN
    parity_load = 1'b0;
`endif
    if (baud_tick) begin
      case (state)
        S_IDLE: begin
          if (rx_inp) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            state_nxt = S_START;
            cnt_nxt   = '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt_nxt = '0;
            if (rx_inp) begin
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_DATA;
              idx_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_FULL) begin
            shift   = 1'b1;
            cnt_nxt = '0;
            idx_nxt = idx + IW'(1);
            if (idx == IDX_LAST) begin
`ifdef RX_SEQ_PARITY_EN
              state_nxt = S_PARITY;
`else
              state_nxt = S_STOP;
`endif
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`ifdef RX_SEQ_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_FULL) begin
            parity_load = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = S_STOP;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_FULL) begin
            check_stop = 1'b1;
            cnt_nxt    = '0;
            idx_nxt    = '0;
            state_nxt  = S_IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Frame handshake: completion wins over frame_ready so a frame landing on
  // the accept cycle stays presented; overrun only clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else if (check_stop) begin
      frame_valid <= 1'b1;
      frame_err   <= err_now;
      if (frame_valid && !frame_ready) begin
        overrun <= 1'b1;
      end
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule
